mlp_wmem_arb: RTL
=================

Name: mlp_wmem_arb

Overview:
- Arbiter for the single-port MLP weight SRAM (2048 words, 11-bit address).
- Shares the port between two requesters:
  - Requester 0: the MLP compute sequencer (weight reads during Acc, stores during InitW).
  - Requester 1: the host init/readback path.
- Fixed priority to compute, with a starvation guard for the host.
- Routes read data back to the issuing requester after a fixed SRAM latency.

Parameters:
- AddrWidth, 11, SRAM word address width.
- DataWidth, 8, SRAM data width.
- ReadLatency, 1, cycles from SRAM enable to valid mem_rdata_i; legal range 1..4.
- MaxWait, 8, consecutive denied host cycles before the host gets priority; legal range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- c_valid_i  in  1  compute request valid.
- c_ready_o  out  1  compute request granted this cycle.
- c_we_i  in  1  compute write (1) / read (0).
- c_addr_i  in  AddrWidth  compute address.
- c_wdata_i  in  DataWidth  compute write data.
- c_rvalid_o  out  1  compute read data valid.
- h_valid_i  in  1  host request valid.
- h_ready_o  out  1  host request granted this cycle.
- h_we_i  in  1  host write (1) / read (0).
- h_addr_i  in  AddrWidth  host address.
- h_wdata_i  in  DataWidth  host write data.
- h_rvalid_o  out  1  host read data valid.
- rdata_o  out  DataWidth  read data, shared; qualified by the rvalid outputs.
- mem_en_o  out  1  SRAM enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrWidth  SRAM address.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data.
- rd_busy_o  out  1  any read in flight.

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - ready is combinational from the valid inputs and the wait counter; there is no registered grant.
  - A requester holds valid, we, addr and wdata stable until ready.
  - At most one grant per cycle.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, compute is granted unless wait_cnt == MaxWait, in which case host is granted.
- SRAM drive:
  - mem_en_o = c_ready_o | h_ready_o, same cycle as the grant.
  - mem_we_o, mem_addr_o and mem_wdata_o are muxed from the granted requester.
  - When no grant: all SRAM outputs are 0.
- Wait counter (8-bit):
  - Increments when h_valid_i && !h_ready_o.
  - Clears when the host is granted, or when h_valid_i is low.
  - Saturates at MaxWait.
- Read tag pipeline:
  - ReadLatency stages, each holding {valid, id}.
  - A granted read enters stage 0 with id = granted requester. Writes enter valid=0.
  - Shifts every cycle; no backpressure.
  - At the last stage: c_rvalid_o or h_rvalid_o per id, asserted for exactly one cycle.
  - rdata_o = mem_rdata_i, unregistered.
- rd_busy_o = OR of all stage valid bits.
- Back-to-back reads from alternating requesters return in issue order, one per cycle.
- Reset (rst_i high at a clock edge):
  - Wait counter and all pipeline stages cleared.
  - While rst_i is high, all ready, rvalid and mem_* outputs are forced to 0.
  - Reads in flight at reset produce no rvalid.
  - Requests presented during reset are not granted.
- Reset values: c_ready_o=0, h_ready_o=0, c_rvalid_o=0, h_rvalid_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o passes mem_rdata_i, rd_busy_o=0.

Decomposition:
- Shared package mlp_pkg holds:
  - localparams WAddrWidth=11, WDataWidth=8.
  - typedef enum logic {ReqCompute, ReqHost} mlp_req_id_t.
  - typedef struct packed {logic valid; mlp_req_id_t id;} mlp_rd_tag_t.
- One sub-module, mlp_tag_delay:
  - Parameterised shift register of mlp_rd_tag_t, depth ReadLatency, synchronous clear.
  - Instantiated once.

Test Plan:
- Solo read: c_valid_i=1, c_we_i=0, addr 0x123 for one cycle.
  - c_ready_o=1 that cycle; mem_en_o=1, mem_addr_o=0x123.
  - With ReadLatency=1 and SRAM returning 0x5A, the next cycle gives c_rvalid_o=1, rdata_o=0x5A, h_rvalid_o=0.
- Contention priority: both valid continuously, MaxWait=8.
  - c_ready_o=1 for cycles 0..7; h_ready_o=1 on cycle 8.
  - Compute is granted on cycle 9 and the wait counter restarts.
- Starvation reset: host valid, denied for 5 cycles, then h_valid_i drops for 1 cycle and reasserts.
  - The host needs a further 8 denied cycles before it is granted.
- Interleaved reads, ReadLatency=3: compute read at cycle 0, host read at cycle 1.
  - c_rvalid_o at cycle 3, h_rvalid_o at cycle 4; rd_busy_o high for cycles 1..4.
- Write, no response: host write addr 0x7FF, data 0xA5.
  - mem_we_o=1, mem_wdata_o=0xA5; no rvalid ever; rd_busy_o stays 0.
- Reset mid-flight, ReadLatency=2: compute read at cycle 0, rst_i=1 at cycle 1.
  - No c_rvalid_o at cycle 2; all outputs 0 during reset; a fresh read after reset returns normally.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types for the MLP weight-memory path: SRAM geometry, requester IDs
// and the read tag carried alongside each in-flight SRAM read.
package mlp_pkg;

   localparam int WAddrWidth = 11;
   localparam int WDataWidth = 8;

   typedef enum logic {
      ReqCompute = 1'b0,
      ReqHost    = 1'b1
   } mlp_req_id_t;

   typedef struct packed {
      logic        valid;
      mlp_req_id_t id;
   } mlp_rd_tag_t;

   localparam mlp_rd_tag_t TagIdle = '{valid: 1'b0, id: ReqCompute};

endpackage

// File: rtl/mlp_tag_delay.sv
// Fixed-depth delay line for read tags. A tag entering on one cycle emerges
// Depth cycles later, lined up with the SRAM read data it describes.
module mlp_tag_delay
   import mlp_pkg::*;
#(
   parameter int Depth = 1
) (
   input  logic        clk_i,
   input  logic        clr_i,
   input  mlp_rd_tag_t tag_i,
   output mlp_rd_tag_t tag_o,
   output logic        busy_o
);

   mlp_rd_tag_t r_stage [Depth];
   logic        w_busy;

   // Shift the tags one stage per cycle; clear drops every in-flight read.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         // NOTE: every stage is cleared, not just stage 0, so a read issued
         // before reset can never surface as a stale rvalid afterwards.
         for (int i = 0; i < Depth; i++) begin
            r_stage[i] <= TagIdle;
         end
      end else begin
         // NOTE: non-blocking assignments make every stage sample its
         // neighbour's old value, so the loop order cannot collapse the line.
         r_stage[0] <= tag_i;
         for (int i = 1; i < Depth; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   // A read is outstanding while any stage still holds a valid tag.
   always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         w_busy = w_busy | r_stage[i].valid;
      end
   end

   assign tag_o  = r_stage[Depth-1];
   assign busy_o = w_busy;

endmodule

// File: rtl/mlp_wmem_arb.sv
// Single-port weight SRAM arbiter. Compute has fixed priority; a host that has
// been refused MaxWait cycles in a row wins the next contention. Read data is
// steered back to its issuer by a tag that travels alongside the SRAM latency.
module mlp_wmem_arb
   import mlp_pkg::*;
#(
   parameter int AddrWidth   = WAddrWidth,
   parameter int DataWidth   = WDataWidth,
   parameter int ReadLatency = 1,
   parameter int MaxWait     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 c_valid_i,
   output logic                 c_ready_o,
   input  logic                 c_we_i,
   input  logic [AddrWidth-1:0] c_addr_i,
   input  logic [DataWidth-1:0] c_wdata_i,
   output logic                 c_rvalid_o,
   input  logic                 h_valid_i,
   output logic                 h_ready_o,
   input  logic                 h_we_i,
   input  logic [AddrWidth-1:0] h_addr_i,
   input  logic [DataWidth-1:0] h_wdata_i,
   output logic                 h_rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 mem_en_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic                 rd_busy_o
);

   logic [7:0]  r_wait_cnt;
   logic        w_host_pri;
   logic        w_c_grant;
   logic        w_h_grant;
   mlp_rd_tag_t w_tag_in;
   mlp_rd_tag_t w_tag_out;
   logic        w_busy;

   // Grant decision: compute wins ties unless the host has waited MaxWait cycles.
   always_comb begin
      w_host_pri = (r_wait_cnt == 8'(MaxWait));
      w_c_grant  = !rst_i && c_valid_i && !(h_valid_i && w_host_pri);
      w_h_grant  = !rst_i && h_valid_i && (!c_valid_i || w_host_pri);
   end

   assign c_ready_o = w_c_grant;
   assign h_ready_o = w_h_grant;

   // Steer the granted requester onto the SRAM port; idle port drives zeros.
   always_comb begin
      // NOTE: every output gets a value before the if/else so no path leaves
      // one unassigned, which would otherwise infer a latch.
      mem_en_o    = w_c_grant | w_h_grant;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_c_grant) begin
         mem_we_o    = c_we_i;
         mem_addr_o  = c_addr_i;
         mem_wdata_o = c_wdata_i;
      end else if (w_h_grant) begin
         mem_we_o    = h_we_i;
         mem_addr_o  = h_addr_i;
         mem_wdata_o = h_wdata_i;
      end
   end

   // Count consecutive refused host cycles, saturating at MaxWait.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wait_cnt <= '0;
      end else if (!h_valid_i || w_h_grant) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != 8'(MaxWait)) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // Only granted reads carry a valid tag; writes enter as bubbles.
   always_comb begin
      w_tag_in.valid = (w_c_grant && !c_we_i) || (w_h_grant && !h_we_i);
      w_tag_in.id    = w_h_grant ? ReqHost : ReqCompute;
   end

   mlp_tag_delay #(
      .Depth (ReadLatency)
   ) u_tag_delay (
      .clk_i  (clk_i),
      .clr_i  (rst_i),
      .tag_i  (w_tag_in),
      .tag_o  (w_tag_out),
      .busy_o (w_busy)
   );

   assign c_rvalid_o = !rst_i && w_tag_out.valid && (w_tag_out.id == ReqCompute);
   assign h_rvalid_o = !rst_i && w_tag_out.valid && (w_tag_out.id == ReqHost);
   assign rd_busy_o  = !rst_i && w_busy;
   assign rdata_o    = mem_rdata_i;

endmodule
